// File: rtl/sync_fifo_ext_if.sv
// Streaming FIFO bus: write side, read side, programmable thresholds and status.
// master drives requests and thresholds; slave (the FIFO) drives data and flags.
interface sync_fifo_ext_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] din;
    logic                  wr_en;
    logic                  full;
    logic                  prog_full;
    logic                  overflow;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic                  prog_empty;
    logic                  underflow;
    logic [ADDR_WIDTH:0]   prog_full_thresh;
    logic [ADDR_WIDTH:0]   prog_empty_thresh;
    logic [ADDR_WIDTH:0]   data_count;

    modport master (
        output din, wr_en, rd_en, prog_full_thresh, prog_empty_thresh,
        input  full, prog_full, overflow, dout, empty, prog_empty, underflow, data_count
    );

    modport slave (
        input  din, wr_en, rd_en, prog_full_thresh, prog_empty_thresh,
        output full, prog_full, overflow, dout, empty, prog_empty, underflow, data_count
    );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO, std (dout 1 cycle after read) or fwft (head shown 2 edges after write).
// Backpressure via registered full/empty; rejected requests raise overflow/underflow for one cycle.
module sync_fifo_ext #(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 4,
    parameter string READ_MODE  = "std",
    parameter string RAM_STYLE  = "distributed"
) (
    input  logic           clk,
    input  logic           rst,
    sync_fifo_ext_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam bit FWFT  = (READ_MODE == "fwft");

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         count;
    logic [PW-1:0]         count_nxt;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] ram_dat;
    logic                  full_q;
    logic                  empty_q;
    logic                  prog_full_q;
    logic                  prog_empty_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_rd;
    logic                  ram_we;
    logic                  ram_nonempty;
    logic                  empty_nxt;

    always_comb begin
        wr_acc       = bus.wr_en & ~full_q;
        rd_acc       = bus.rd_en & ~empty_q;
        ram_we       = wr_acc & ~rst;
        ram_nonempty = (wr_ptr != rd_ptr);
        count_nxt    = count + PW'(wr_acc) - PW'(rd_acc);
        // In fwft, ~empty_q is the valid bit of the output register; refill it whenever
        // it is idle or being consumed, so back-to-back reads never bubble.
        if (FWFT) begin
            ram_rd    = (empty_q | rd_acc) & ram_nonempty;
            empty_nxt = ~(ram_rd | (~empty_q & ~rd_acc));
        end else begin
            ram_rd    = rd_acc;
            empty_nxt = (count_nxt == '0);
        end
    end

    generate
        if (RAM_STYLE == "block") begin : g_bram
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
            always_ff @(posedge clk) begin
                if (ram_we) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.din;
            end
            assign ram_dat = mem[rd_ptr[ADDR_WIDTH-1:0]];
        end else begin : g_dram
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
            always_ff @(posedge clk) begin
                if (ram_we) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.din;
            end
            assign ram_dat = mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            dout_q       <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (ram_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
                dout_q <= ram_dat;
            end
            count        <= count_nxt;
            full_q       <= (count_nxt == PW'(DEPTH));
            empty_q      <= empty_nxt;
            prog_full_q  <= (count_nxt >= bus.prog_full_thresh);
            prog_empty_q <= (count_nxt <= bus.prog_empty_thresh);
            overflow_q   <= bus.wr_en & full_q;
            underflow_q  <= bus.rd_en & empty_q;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.prog_full  = prog_full_q;
    assign bus.prog_empty = prog_empty_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
    assign bus.data_count = count;
endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
- Parametrised successor to the team's single-clock register-array FIFO.
- Adds:
  - selectable read mode ("std" or "fwft" with a registered output stage);
  - an occupancy counter;
  - runtime-programmable almost-full/almost-empty thresholds;
  - overflow/underflow error pulses.
- Used as the general buffering primitive between streaming stages in one clock domain.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, log2 of depth. DEPTH = 2**ADDR_WIDTH; legal range 2..12.
- READ_MODE, "std", "std" = dout updates one cycle after an accepted read; "fwft" = head word presented on dout while empty is low.
- RAM_STYLE, "distributed", synthesis attribute on the storage array ("distributed" or "block").

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- full  out  1  no free slot; writes ignored.
- prog_full  out  1  data_count >= prog_full_thresh.
- overflow  out  1  one-cycle pulse: previous-cycle write rejected.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  read data.
- empty  out  1  no readable word.
- prog_empty  out  1  data_count <= prog_empty_thresh.
- underflow  out  1  one-cycle pulse: previous-cycle read rejected.
- prog_full_thresh  in  ADDR_WIDTH+1  almost-full threshold, sampled every cycle.
- prog_empty_thresh  in  ADDR_WIDTH+1  almost-empty threshold, sampled every cycle.
- data_count  out  ADDR_WIDTH+1  words held, 0..DEPTH.

Behaviour:
- Reset (rst high at a clk edge):
  - pointers and counter go to 0;
  - empty=1, prog_empty=1, full=0, prog_full=0, overflow=0, underflow=0, dout=0, data_count=0;
  - FWFT output stage is invalidated;
  - RAM contents are not cleared.
  - Reset mid-operation discards all data.
  - A wr_en/rd_en in the reset cycle has no effect.
- Pointers:
  - ADDR_WIDTH+1 bits; low bits address the RAM, MSB is the wrap bit.
  - Increment modulo 2**(ADDR_WIDTH+1).
- Accept rules, evaluated against current registered flags:
  - write accepted = wr_en & ~full;
  - read accepted = rd_en & ~empty.
  - A rejected write sets overflow for the next cycle only. A rejected read does the same for underflow.
- Simultaneous accepted read and write: data_count unchanged.
  - At full: the write is rejected, the read is accepted, count becomes DEPTH-1, overflow pulses.
  - At empty: the read is rejected, the write is accepted, underflow pulses.
- Registered flags:
  - All status outputs are registered, computed from the next-state count.
  - They are valid in the cycle after the causing operation, with no lag beyond that.
- Std mode:
  - data_count = words in RAM.
  - Accepted read at edge N: dout = head word after edge N. dout holds its value otherwise, including while empty.
  - Write at edge N into an empty FIFO: empty=0 after edge N. A read at edge N+1 gives dout after edge N+1.
- FWFT mode:
  - One output register (valid bit) is prefetched from RAM whenever it is invalid, or being consumed, and RAM is non-empty.
  - empty = ~valid.
  - data_count = RAM words + valid.
  - full when data_count == DEPTH.
  - Write at edge N into an empty FIFO: RAM has it after N, output register loads at N+1. empty=0 and dout=din after edge N+1 (two-edge latency).
  - Back-to-back reads with ≥2 words stored: one word per cycle, no bubbles.
  - When drained, dout holds the last word read.
- Programmable flags:
  - prog_full and prog_empty follow the threshold inputs live; a threshold change is reflected after the next edge.
  - prog_full_thresh=0 forces prog_full=1.
  - prog_empty_thresh >= DEPTH forces prog_empty=1.
- Capacity: exactly DEPTH words in both modes. The pointer wrap at 2*DEPTH writes is seamless.

Test Plan:
- Std, DEPTH=16: write 0x00..0x0F.
  - full=1 and data_count=16 after the 16th write.
  - A 17th write → overflow pulse one cycle, data unchanged.
  - Read 16 → dout 0x00..0x0F in order; empty=1 after the 16th read.
  - A further read → underflow pulse.
- FWFT: single write 0xA5 at edge N into an empty FIFO → empty falls and dout=0xA5 after edge N+1. rd_en at N+2 → empty=1, dout stays 0xA5.
- Full with wr_en=rd_en=1 for 1 cycle → count 15, overflow=1, oldest word out. Then both high on a half-full FIFO for 40 cycles → count constant and data order preserved across the pointer wrap.
- Thresholds prog_full_thresh=12, prog_empty_thresh=3:
  - prog_empty drops after the 4th write;
  - prog_full rises after the 12th write;
  - changing prog_full_thresh to 14 at count 12 → prog_full=0 next cycle.
- Reset mid-operation at count 9 (FWFT, dout valid) → next cycle all flags and count at reset values. A following write/read returns only post-reset data.
- Random wr_en/rd_en (50%) for 10k cycles, both modes, against a queue model → dout, data_count and all flags match every cycle.
